cmd_sequencer: RTL and testbench

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_cmd_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sequencer.sv
// Per-tick command sequencer for two tanks: latches move/fire requests and
// issues ordered storage writes for each tank's movement and projectile.
module cmd_sequencer #(
    parameter int PROJ_RANGE = 15,
    parameter int SETTLE     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] t1_key,
    input  logic       t1_fire,
    input  logic [3:0] t2_key,
    input  logic       t2_fire,
    output logic [3:0] mode,
    output logic       wren,
    output logic [7:0] address,
    output logic [7:0] data,
    output logic       busy,
    output logic       overrun
);

    localparam int LW = (PROJ_RANGE < 2) ? 1 : $clog2(PROJ_RANGE + 1);
    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_ADVANCE} state_t;

    state_t             state_q, state_next;
    logic [1:0]         slot;
    logic [SW-1:0]      settle_cnt;
    logic [1:0][3:0]    key_pend;
    logic [1:0]         fire_pend;
    logic [1:0][7:0]    last_dir;
    logic [1:0][7:0]    proj_dir;
    logic [1:0]         in_flight;
    logic [1:0][LW-1:0] life;

    logic [1:0][3:0]    key_in;
    logic [1:0]         fire_in;
    logic               tank;
    logic               is_proj;
    logic               slot_active;
    logic [7:0]         wr_data;

    assign key_in  = {t2_key, t1_key};
    assign fire_in = {t2_fire, t1_fire};
    assign tank    = slot[1];
    assign is_proj = slot[0];
    assign address = 8'h00;

    function automatic logic [7:0] resolve_dir(input logic [3:0] k);
        if (k[3])      return 8'h00;
        else if (k[2]) return 8'h01;
        else if (k[1]) return 8'h03;
        else           return 8'h07;
    endfunction

    // NOTE: every signal written here gets a default first, so no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        slot_active = 1'b0;
        wr_data     = 8'h00;
        state_next  = state_q;
        if (is_proj) begin
            slot_active = in_flight[tank] | fire_pend[tank];
            wr_data     = in_flight[tank] ? proj_dir[tank] : last_dir[tank];
        end else begin
            slot_active = |key_pend[tank];
            wr_data     = resolve_dir(key_pend[tank]);
        end
        unique case (state_q)
            ST_IDLE:    if (tick) state_next = ST_ISSUE;
            ST_ISSUE:   state_next = slot_active ? ST_SETTLE : ST_ADVANCE;
            ST_SETTLE:  if (settle_cnt == '0) state_next = ST_ADVANCE;
            ST_ADVANCE: state_next = (slot == 2'd3) ? ST_IDLE : ST_ISSUE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_next;
    end

    // NOTE: the small per-tank register arrays are reset like ordinary flops; the storage-side reset directions are mirrored here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode       <= 4'b0000;
            wren       <= 1'b0;
            data       <= 8'h00;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            slot       <= 2'd0;
            settle_cnt <= '0;
            key_pend   <= '0;
            fire_pend  <= '0;
            last_dir   <= {8'h00, 8'h01};
            proj_dir   <= '0;
            in_flight  <= '0;
            life       <= '0;
        end else begin
            wren      <= 1'b0;
            overrun   <= tick && (state_q != ST_IDLE);
            key_pend  <= key_pend | key_in;
            fire_pend <= fire_pend | fire_in;
            unique case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        slot <= 2'd0;
                        busy <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (slot_active) begin
                        wren       <= 1'b1;
                        mode       <= {1'b0, slot, 1'b1};
                        data       <= wr_data;
                        settle_cnt <= SW'(SETTLE);
                    end
                    if (!is_proj) begin
                        // Lower-priority bits are dropped; only fresh requests survive.
                        key_pend[tank] <= key_in[tank];
                        if (slot_active) last_dir[tank] <= wr_data;
                    end else begin
                        fire_pend[tank] <= fire_in[tank];
                        if (in_flight[tank]) begin
                            life[tank] <= life[tank] - 1'b1;
                            if (life[tank] == LW'(1)) in_flight[tank] <= 1'b0;
                        end else if (fire_pend[tank]) begin
                            // The launch write is the first of PROJ_RANGE, so it is pre-counted.
                            proj_dir[tank]  <= last_dir[tank];
                            life[tank]      <= LW'(PROJ_RANGE - 1);
                            in_flight[tank] <= (PROJ_RANGE > 1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                ST_ADVANCE: begin
                    slot <= slot + 2'd1;
                    if (slot == 2'd3) begin
                        busy <= 1'b0;
                        mode <= 4'b0000;
                        data <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Randomized and directed bench for cmd_sequencer against a per-tick
// behavioural model of the expected write list.
module tb_cmd_sequencer;

    localparam int PR = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] t1_key = 4'h0;
    logic       t1_fire = 1'b0;
    logic [3:0] t2_key = 4'h0;
    logic       t2_fire = 1'b0;
    logic [3:0] mode;
    logic       wren;
    logic [7:0] address;
    logic [7:0] data;
    logic       busy;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;

    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];

    // Model state: sticky requests, last direction, projectile direction and
    // number of in-flight writes still owed.
    logic [3:0] m_key[2];
    logic       m_fire[2];
    logic [7:0] m_last[2];
    logic [7:0] m_pdir[2];
    int         m_rem[2];

    cmd_sequencer #(.PROJ_RANGE(PR), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .t1_key(t1_key), .t1_fire(t1_fire), .t2_key(t2_key), .t2_fire(t2_fire),
        .mode(mode), .wren(wren), .address(address), .data(data),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b1 && wren === 1'b1) got_q.push_back({address, mode, data});
        if (overrun === 1'b1) ovr_cnt++;
    end

    task automatic model_reset();
        for (int t = 0; t < 2; t++) begin
            m_key[t] = 4'h0; m_fire[t] = 1'b0; m_pdir[t] = 8'h00; m_rem[t] = 0;
        end
        m_last[0] = 8'h01;
        m_last[1] = 8'h00;
    endtask

    task automatic model_inputs(input logic [3:0] k1, input logic f1, input logic [3:0] k2, input logic f2);
        m_key[0] |= k1; m_fire[0] |= f1;
        m_key[1] |= k2; m_fire[1] |= f2;
    endtask

    task automatic model_sequence();
        logic [7:0] d;
        exp_q.delete();
        for (int t = 0; t < 2; t++) begin
            if (m_key[t] != 4'h0) begin
                d = m_key[t][3] ? 8'h00 : m_key[t][2] ? 8'h01 : m_key[t][1] ? 8'h03 : 8'h07;
                exp_q.push_back({8'h00, (t == 1) ? 4'b0101 : 4'b0001, d});
                m_last[t] = d;
                m_key[t] = 4'h0;
            end
            if (m_rem[t] > 0) begin
                exp_q.push_back({8'h00, (t == 1) ? 4'b0111 : 4'b0011, m_pdir[t]});
                m_rem[t]--;
            end else if (m_fire[t]) begin
                exp_q.push_back({8'h00, (t == 1) ? 4'b0111 : 4'b0011, m_last[t]});
                m_pdir[t] = m_last[t];
                m_rem[t] = PR - 1;
            end
            m_fire[t] = 1'b0;
        end
    endtask

    task automatic set_inputs(input logic [3:0] k1, input logic f1, input logic [3:0] k2, input logic f2);
        t1_key = k1; t1_fire = f1; t2_key = k2; t2_fire = f2;
        model_inputs(k1, f1, k2, f2);
    endtask

    task automatic pulse_inputs(input logic [3:0] k1, input logic f1, input logic [3:0] k2, input logic f2);
        @(negedge clk);
        set_inputs(k1, f1, k2, f2);
        @(negedge clk);
        set_inputs(4'h0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic compare_writes(input string name);
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s write_count: got %0d writes, required %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                if (got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL %s write[%0d]: got addr/mode/data %h, required %h", name, i, got_q[i], exp_q[i]);
                    break;
                end
            end
        end
    endtask

    // One tick with optional same-cycle inputs, checked against the model.
    task automatic run_seq(input logic [3:0] k1, input logic f1, input logic [3:0] k2, input logic f2,
                           input string name);
        got_q.delete();
        @(negedge clk);
        set_inputs(k1, f1, k2, f2);
        tick = 1'b1;
        model_sequence();
        @(negedge clk);
        set_inputs(4'h0, 1'b0, 4'h0, 1'b0);
        tick = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_rise: busy=%b, required 1", name, busy);
        end
        wait_idle(name);
        compare_writes(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        set_inputs(4'h0, 1'b0, 4'h0, 1'b0);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({mode, wren, address, data, busy, overrun} !== 23'h0) begin
            fails++;
            $display("FAIL reset_outputs: mode=%b wren=%b addr=%h data=%h busy=%b ovr=%b, required all 0",
                     mode, wren, address, data, busy, overrun);
        end
        do_reset();
        got_q.delete();
        repeat (10) @(negedge clk);
        tests++;
        if (got_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_quiet: writes=%0d busy=%b, required 0 writes busy 0", got_q.size(), busy);
        end
    endtask

    task automatic test_single_move();
        pulse_inputs(4'b0100, 1'b0, 4'h0, 1'b0);
        run_seq(4'h0, 1'b0, 4'h0, 1'b0, "t1_down");
        tests++;
        if (got_q.size() != 1 || got_q[0] !== {8'h00, 4'b0001, 8'h01}) begin
            fails++;
            $display("FAIL t1_down_write: got %0d writes first %h, required 1 write 00101", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 20'h0);
        end
        tests++;
        if (mode !== 4'b0000 || data !== 8'h00) begin
            fail_idle_outputs("t1_down_idle");
        end
    endtask

    task automatic fail_idle_outputs(input string name);
        fails++;
        $display("FAIL %s: mode=%b data=%h, required 0000 00", name, mode, data);
    endtask

    task automatic test_priority();
        pulse_inputs(4'h0, 1'b0, 4'b1111, 1'b0);
        run_seq(4'h0, 1'b0, 4'h0, 1'b0, "t2_all_keys");
        tests++;
        if (got_q.size() != 1 || got_q[0] !== {8'h00, 4'b0101, 8'h00}) begin
            fails++;
            $display("FAIL t2_priority_write: got %0d writes first %h, required 1 write 00500", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 20'h0);
        end
        run_seq(4'h0, 1'b0, 4'h0, 1'b0, "t2_discarded");
        tests++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL t2_lower_bits_discarded: got %0d writes, required 0", got_q.size());
        end
    endtask

    task automatic test_projectile();
        int bad = 0;
        do_reset();
        pulse_inputs(4'h0, 1'b1, 4'h0, 1'b0);
        run_seq(4'h0, 1'b0, 4'h0, 1'b0, "t1_launch");
        tests++;
        if (got_q.size() != 1 || got_q[0] !== {8'h00, 4'b0011, 8'h01}) begin
            fails++;
            $display("FAIL t1_launch_write: got %0d writes, required 1 write 00301", got_q.size());
        end
        for (int i = 0; i < PR - 1; i++) begin
            run_seq(4'h0, 1'b0, 4'h0, 1'b0, "t1_flight");
            if (got_q.size() != 1 || got_q[0] !== {8'h00, 4'b0011, 8'h01}) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL t1_flight_writes: %0d ticks wrong, required 0", bad);
        end
        run_seq(4'h0, 1'b0, 4'h0, 1'b0, "t1_expired");
        tests++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL t1_expired: got %0d writes, required 0", got_q.size());
        end
    endtask

    task automatic test_fire_in_flight();
        int proj_ticks = 0;
        int bad_dir = 0;
        pulse_inputs(4'b0010, 1'b0, 4'h0, 1'b0);
        run_seq(4'h0, 1'b0, 4'h0, 1'b0, "t1_left");
        pulse_inputs(4'h0, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < PR + 3; i++) begin
            if (i == 3) pulse_inputs(4'b1000, 1'b1, 4'h0, 1'b0);
            run_seq(4'h0, 1'b0, 4'h0, 1'b0, "refire");
            foreach (got_q[j]) begin
                if (got_q[j][11:8] == 4'b0011) begin
                    proj_ticks++;
                    if (got_q[j][7:0] !== 8'h03) bad_dir++;
                end
            end
        end
        tests++;
        if (proj_ticks != PR || bad_dir != 0) begin
            fails++;
            $display("FAIL refire_ignored: %0d projectile writes (%0d wrong dir), required %0d (0)",
                     proj_ticks, bad_dir, PR);
        end
    endtask

    task automatic test_overrun();
        got_q.delete();
        @(negedge clk);
        set_inputs(4'b1000, 1'b0, 4'b0001, 1'b0);
        tick = 1'b1;
        model_sequence();
        ovr_cnt = 0;
        @(negedge clk);
        set_inputs(4'h0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        tick = 1'b0;
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_pulse: overrun=%b, required 1", overrun);
        end
        @(negedge clk);
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_width: overrun=%b one cycle later, required 0", overrun);
        end
        wait_idle("overrun");
        compare_writes("overrun");
        tests++;
        if (ovr_cnt != 1) begin
            fails++;
            $display("FAIL overrun_count: %0d pulse cycles, required 1", ovr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        @(negedge clk);
        set_inputs(4'b0001, 1'b0, 4'b0010, 1'b0);
        tick = 1'b1;
        @(negedge clk);
        set_inputs(4'h0, 1'b0, 4'h0, 1'b0);
        tick = 1'b0;
        while (wren !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (wren !== 1'b1 || mode !== 4'b0001 || data !== 8'h07) begin
            fails++;
            $display("FAIL midreset_first_write: wren=%b mode=%b data=%h, required 1 0001 07", wren, mode, data);
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({mode, wren, address, data, busy, overrun} !== 23'h0) begin
            fails++;
            $display("FAIL midreset_outputs: mode=%b wren=%b data=%h busy=%b, required all 0", mode, wren, data, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        got_q.delete();
        repeat (20) @(negedge clk);
        tests++;
        if (got_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_aborted: writes=%0d busy=%b, required 0 and 0", got_q.size(), busy);
        end
        run_seq(4'h0, 1'b0, 4'h0, 1'b0, "after_midreset");
    endtask

    task automatic test_random();
        logic [3:0] k1, k2;
        logic f1, f2;
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(1, 0) == 1) begin
                k1 = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0;
                k2 = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0;
                f1 = ($urandom_range(3, 0) == 0);
                f2 = ($urandom_range(3, 0) == 0);
                pulse_inputs(k1, f1, k2, f2);
            end
            k1 = 4'h0; k2 = 4'h0; f1 = 1'b0; f2 = 1'b0;
            if ($urandom_range(2, 0) == 0) begin
                k1 = 4'($urandom);
                k2 = 4'($urandom);
                f1 = ($urandom_range(3, 0) == 0);
                f2 = ($urandom_range(3, 0) == 0);
            end
            run_seq(k1, f1, k2, f2, "random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_move();
        test_priority();
        test_projectile();
        test_fire_in_flight();
        test_overrun();
        test_reset_mid();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
